// File: rtl/rssi_apb_pkg.sv
// Shared register map and CTRL bit positions for the RSSI APB monitor.
package rssi_apb_pkg;

  localparam logic [11:0] ADDR_ID      = 12'h000;
  localparam logic [11:0] ADDR_CTRL    = 12'h004;
  localparam logic [11:0] ADDR_FLAGS   = 12'h008;
  localparam logic [11:0] ADDR_IRQ_EN  = 12'h00C;
  localparam logic [11:0] ADDR_THRESH  = 12'h010;
  localparam logic [11:0] ADDR_SNAPSEQ = 12'h014;
  localparam logic [11:0] SNAP_BASE    = 12'h040;
  localparam logic [11:0] PEAK_BASE    = 12'h080;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_SNAP     = 1;
  localparam int CTRL_PEAK_CLR = 2;

endpackage

// File: rtl/rssi_chan_track.sv
// One RSSI channel: latest sample, peak-hold and sticky threshold flag.
module rssi_chan_track
  import rssi_apb_pkg::*;
#(
  parameter int RSSI_W = 27
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [RSSI_W-1:0] sample,
  input  logic              vld,
  input  logic              en,
  input  logic [RSSI_W-1:0] thresh,
  input  logic              peak_clr,
  input  logic              flag_clr,
  output logic [RSSI_W-1:0] latest,
  output logic [RSSI_W-1:0] peak,
  output logic              flag
);

  logic take;
  logic hit;

  assign take = vld & en;
  assign hit  = take && (sample >= thresh);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      latest <= '0;
      peak   <= '0;
      flag   <= 1'b0;
    end else begin
      if (take) latest <= sample;
      // A sample landing with the clear starts the new peak window.
      if (peak_clr)                   peak <= take ? sample : '0;
      else if (take && sample > peak) peak <= sample;
      if (hit)           flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;
    end
  end

endmodule

// File: rtl/rssi_apb_monitor.sv
// APB3 slave tracking NUM_CH RSSI streams with peak-hold, threshold flags,
// atomic snapshot shadows and a level interrupt.
module rssi_apb_monitor
  import rssi_apb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int RSSI_W = 27
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic [11:2]              PADDR,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PWDATA,
  input  logic [3:0]               ECOREVNUM,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [NUM_CH*RSSI_W-1:0] rssi_in,
  input  logic [NUM_CH-1:0]        rssi_vld,
  output logic                     irq
);

  logic [11:0]       addr;
  logic [3:0]        ch_idx;
  logic              mapped;
  logic [31:0]       rd_val;
  logic              wr_access;
  logic              rd_setup;
  logic              snap;
  logic              peak_clr;
  logic [NUM_CH-1:0] flag_clr;

  logic              en;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] flags;
  logic [RSSI_W-1:0] thresh;
  logic [15:0]       snap_seq;
  logic [RSSI_W-1:0] latest  [NUM_CH];
  logic [RSSI_W-1:0] peak    [NUM_CH];
  logic [RSSI_W-1:0] snap_sh [NUM_CH];

  // Upper write-data bits are don't-care for every register.
  logic unused_pwdata;
  assign unused_pwdata = ^PWDATA;

  assign addr      = {PADDR, 2'b00};
  assign ch_idx    = addr[5:2];
  assign wr_access = PSEL & PENABLE & PWRITE & mapped;
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign snap      = wr_access && (addr == ADDR_CTRL) && PWDATA[CTRL_SNAP];
  assign peak_clr  = wr_access && (addr == ADDR_CTRL) && PWDATA[CTRL_PEAK_CLR];
  assign flag_clr  = (wr_access && (addr == ADDR_FLAGS)) ? PWDATA[NUM_CH-1:0] : '0;

  assign PREADY  = 1'b1;
  assign PSLVERR = PRESETn & PSEL & PENABLE & ~mapped;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    rssi_chan_track #(.RSSI_W(RSSI_W)) u_chan (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .sample   (rssi_in[c*RSSI_W +: RSSI_W]),
      .vld      (rssi_vld[c]),
      .en       (en),
      .thresh   (thresh),
      .peak_clr (peak_clr),
      .flag_clr (flag_clr[c]),
      .latest   (latest[c]),
      .peak     (peak[c]),
      .flag     (flags[c])
    );
  end

  // NOTE: defaults up front keep this block purely combinational (no latches).
  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    case (addr)
      ADDR_ID:      begin mapped = 1'b1; rd_val = {ECOREVNUM, 12'h0, 8'(NUM_CH), 8'(RSSI_W)}; end
      ADDR_CTRL:    begin mapped = 1'b1; rd_val = 32'(en);       end
      ADDR_FLAGS:   begin mapped = 1'b1; rd_val = 32'(flags);    end
      ADDR_IRQ_EN:  begin mapped = 1'b1; rd_val = 32'(irq_en);   end
      ADDR_THRESH:  begin mapped = 1'b1; rd_val = 32'(thresh);   end
      ADDR_SNAPSEQ: begin mapped = 1'b1; rd_val = 32'(snap_seq); end
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_idx == 4'(c)) begin
            if (addr[11:6] == SNAP_BASE[11:6]) begin
              mapped = 1'b1;
              rd_val = 32'(snap_sh[c]);
            end else if (addr[11:6] == PEAK_BASE[11:6]) begin
              mapped = 1'b1;
              rd_val = 32'(peak[c]);
            end
          end
        end
      end
    endcase
  end

  // NOTE: shadows are software-visible registers, so they take the reset like the rest.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en       <= 1'b0;
      irq_en   <= '0;
      thresh   <= '0;
      snap_seq <= '0;
      PRDATA   <= '0;
      irq      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) snap_sh[c] <= '0;
    end else begin
      if (wr_access) begin
        case (addr)
          ADDR_CTRL:   en     <= PWDATA[CTRL_EN];
          ADDR_IRQ_EN: irq_en <= PWDATA[NUM_CH-1:0];
          ADDR_THRESH: thresh <= PWDATA[RSSI_W-1:0];
          default: ;
        endcase
      end
      if (snap) begin
        snap_seq <= snap_seq + 16'd1;
        for (int c = 0; c < NUM_CH; c++) snap_sh[c] <= latest[c];
      end
      if (rd_setup) PRDATA <= rd_val;
      irq <= |(flags & irq_en);
    end
  end

endmodule

// File: tb/tb_rssi_apb_monitor.sv
// Self-checking bench for rssi_apb_monitor: directed scenarios plus randomized
// traffic checked against a behavioural model of the register map.
module tb_rssi_apb_monitor;

  localparam int NUM_CH = 4;
  localparam int RSSI_W = 27;

  logic                     PCLK = 1'b0;
  logic                     PRESETn;
  logic                     PSEL;
  logic [11:2]              PADDR;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [31:0]              PWDATA;
  logic [3:0]               ECOREVNUM;
  logic [31:0]              PRDATA;
  logic                     PREADY;
  logic                     PSLVERR;
  logic [NUM_CH*RSSI_W-1:0] rssi_in;
  logic [NUM_CH-1:0]        rssi_vld;
  logic                     irq;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int unsigned m_latest [NUM_CH];
  int unsigned m_peak   [NUM_CH];
  int unsigned m_snap   [NUM_CH];
  bit [3:0]    m_flags;
  bit [3:0]    m_irq_en;
  int unsigned m_thresh;
  int unsigned m_seq;
  bit          m_en;
  bit          m_irq;
  logic [31:0] m_prdata;
  bit          rand_mode = 1'b0;

  rssi_apb_monitor #(.NUM_CH(NUM_CH), .RSSI_W(RSSI_W)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PSEL      (PSEL),
    .PADDR     (PADDR),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .ECOREVNUM (ECOREVNUM),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .rssi_in   (rssi_in),
    .rssi_vld  (rssi_vld),
    .irq       (irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_latest[c] = 0;
      m_peak[c]   = 0;
      m_snap[c]   = 0;
    end
    m_flags = '0; m_irq_en = '0; m_thresh = 0; m_seq = 0;
    m_en = 1'b0; m_irq = 1'b0; m_prdata = '0;
  endtask

  function automatic void model_read(input logic [11:0] a, output bit mapped, output logic [31:0] d);
    int ch;
    ch     = int'(a[5:2]);
    mapped = 1'b1;
    d      = '0;
    case (a)
      12'h000: d = {ECOREVNUM, 12'h0, 8'd4, 8'd27};
      12'h004: d = {31'b0, m_en};
      12'h008: d = {28'b0, m_flags};
      12'h00C: d = {28'b0, m_irq_en};
      12'h010: d = m_thresh;
      12'h014: d = m_seq;
      default: begin
        if (a >= 12'h040 && a < 12'h040 + 4*NUM_CH)      d = m_snap[ch];
        else if (a >= 12'h080 && a < 12'h080 + 4*NUM_CH) d = m_peak[ch];
        else mapped = 1'b0;
      end
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven, then clock the DUT.
  task automatic tick();
    logic [11:0]       a;
    logic [31:0]       d;
    logic [RSSI_W-1:0] rv;
    bit                wr, rd, mp, snap_cmd, clr_cmd, v, irq_next;
    bit [3:0]          fl;
    int unsigned       s;
    a        = {PADDR, 2'b00};
    wr       = PSEL && PENABLE && PWRITE;
    rd       = PSEL && !PENABLE && !PWRITE;
    model_read(a, mp, d);
    if (rd) m_prdata = d;
    irq_next = |(m_flags & m_irq_en);
    wr       = wr && mp;
    snap_cmd = wr && a == 12'h004 && PWDATA[1];
    clr_cmd  = wr && a == 12'h004 && PWDATA[2];
    fl       = m_flags;
    if (wr && a == 12'h008) fl = fl & ~PWDATA[3:0];
    if (snap_cmd) begin
      for (int c = 0; c < NUM_CH; c++) m_snap[c] = m_latest[c];
      m_seq = (m_seq + 1) % 65536;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      v = rssi_vld[c] && m_en;
      s = rssi_in[c*RSSI_W +: RSSI_W];
      if (clr_cmd)             m_peak[c] = v ? s : 0;
      else if (v && s > m_peak[c]) m_peak[c] = s;
      if (v) m_latest[c] = s;
      if (v && s >= m_thresh) fl[c] = 1'b1;
    end
    m_flags = fl;
    if (wr && a == 12'h004) m_en     = PWDATA[0];
    if (wr && a == 12'h00C) m_irq_en = PWDATA[3:0];
    if (wr && a == 12'h010) m_thresh = PWDATA[RSSI_W-1:0];
    m_irq = irq_next;
    @(posedge PCLK);
    #1;
    rssi_vld = '0;
    if (rand_mode) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rssi_vld[c] = 1'($urandom_range(0, 1));
        rv = ($urandom_range(0, 9) == 0) ? {RSSI_W{1'b1}} : RSSI_W'($urandom_range(0, 600));
        rssi_in[c*RSSI_W +: RSSI_W] = rv;
      end
    end
  endtask

  task automatic drive_sample(input int ch, input int unsigned val);
    rssi_in[ch*RSSI_W +: RSSI_W] = val[RSSI_W-1:0];
    rssi_vld[ch] = 1'b1;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a[11:2];
    tick();
    PENABLE = 1'b1;
    #2;
    err = PSLVERR;
    d   = PRDATA;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // vch >= 0 adds a sample on channel vch on the write's commit edge.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] data,
                           input int vch, input int unsigned vval, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a[11:2]; PWDATA = data;
    tick();
    PENABLE = 1'b1;
    if (vch >= 0) drive_sample(vch, vval);
    #2;
    err = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    ECOREVNUM = 4'h3; rssi_in = '0; rssi_vld = '0;
    model_reset();
    #12;
    total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL pready: got %b want 1", PREADY); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb_read(12'h000, d, e);
    total++; if (d !== 32'h3000_041B) begin bad++; $display("FAIL id_read: got %h want 3000041b", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL id_pslverr: got %b want 0", e); end
  endtask

  task automatic test_peak();
    logic [31:0] d;
    logic        e;
    apb_write(12'h004, 32'h1, -1, 0, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ctrl_wr_err: got %b want 0", e); end
    drive_sample(1, 100); tick();
    drive_sample(1, 500); tick();
    drive_sample(1, 200); tick();
    apb_read(12'h084, d, e);
    total++; if (d !== 32'd500) begin bad++; $display("FAIL peak1_hold: got %0d want 500", d); end
    apb_write(12'h004, 32'h5, 1, 7, e);
    apb_read(12'h084, d, e);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL peak1_clr_same_edge: got %0d want 7", d); end
  endtask

  task automatic test_flags();
    logic [31:0] d;
    logic        e;
    apb_write(12'h010, 32'd300, -1, 0, e);
    apb_write(12'h008, 32'hF, -1, 0, e);
    apb_write(12'h00C, 32'h2, -1, 0, e);
    apb_read(12'h008, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL flags_cleared: got %h want 0", d); end
    drive_sample(1, 300); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_latency_early: got %b want 0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_latency: got %b want 1", irq); end
    apb_read(12'h008, d, e);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL flags_set_at_thresh: got %h want 2", d); end
    apb_write(12'h008, 32'h2, 1, 400, e);
    apb_read(12'h008, d, e);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL flags_set_wins: got %h want 2", d); end
    apb_write(12'h008, 32'h2, -1, 0, e);
    apb_read(12'h008, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL flags_w1c: got %h want 0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_w1c: got %b want 0", irq); end
  endtask

  task automatic test_snap();
    logic [31:0] d;
    logic        e;
    drive_sample(0, 10); tick();
    apb_write(12'h004, 32'h3, 0, 20, e);
    apb_read(12'h040, d, e);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL snap0_pre_update: got %0d want 10", d); end
    apb_read(12'h014, d, e);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL snapseq_1: got %0d want 1", d); end
    apb_write(12'h004, 32'h3, -1, 0, e);
    apb_read(12'h040, d, e);
    total++; if (d !== 32'd20) begin bad++; $display("FAIL snap0_second: got %0d want 20", d); end
    apb_read(12'h014, d, e);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL snapseq_2: got %0d want 2", d); end
    // Hold the access phase so every edge commits another SNAP.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h001; PWDATA = 32'h3;
    tick();
    PENABLE = 1'b1;
    repeat (65533) tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb_read(12'h014, d, e);
    total++; if (d !== 32'hFFFF) begin bad++; $display("FAIL snapseq_max: got %h want ffff", d); end
    apb_write(12'h004, 32'h3, -1, 0, e);
    apb_read(12'h014, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL snapseq_wrap: got %h want 0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic        e;
    apb_read(12'h050, d, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_ch4: got %b want 1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL data_ch4: got %h want 0", d); end
    apb_read(12'h200, d, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_0x200: got %b want 1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL data_0x200: got %h want 0", d); end
    apb_write(12'h000, 32'hFFFF_FFFF, -1, 0, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ro_write_err: got %b want 0", e); end
    apb_read(12'h000, d, e);
    total++; if (d !== 32'h3000_041B) begin bad++; $display("FAIL ro_write_ignored: got %h want 3000041b", d); end
    apb_write(12'h050, 32'd123, -1, 0, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL unmapped_write_err: got %b want 1", e); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    logic        e;
    apb_write(12'h004, 32'h0, -1, 0, e);
    drive_sample(2, 999); tick();
    apb_read(12'h088, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL peak2_disabled: got %0d want 0", d); end
    apb_read(12'h008, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL flags_disabled: got %h want 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, x;
    logic [11:0] a;
    logic        e;
    bit          mp;
    logic [11:0] rd_addrs [12] = '{12'h008, 12'h014, 12'h040, 12'h044, 12'h048, 12'h04C,
                                   12'h080, 12'h084, 12'h088, 12'h08C, 12'h00C, 12'h0B0};
    apb_write(12'h010, 32'd300, -1, 0, e);
    apb_write(12'h00C, $urandom_range(0, 15), -1, 0, e);
    apb_write(12'h004, 32'h1, -1, 0, e);
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: apb_write(12'h004, {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1}, -1, 0, e);
        1: apb_write(12'h008, $urandom_range(0, 15), -1, 0, e);
        2: apb_write(12'h00C, $urandom_range(0, 15), -1, 0, e);
        default: begin
          a = rd_addrs[$urandom_range(0, 11)];
          model_read(a, mp, x);
          apb_read(a, d, e);
          total++; if (d !== m_prdata) begin bad++; $display("FAIL rand_read[%h]: got %h want %h", a, d, m_prdata); end
          total++; if (e !== !mp) begin bad++; $display("FAIL rand_err[%h]: got %b want %b", a, e, !mp); end
        end
      endcase
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, m_irq); end
    end
    rand_mode = 1'b0;
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      apb_read(12'h080 + 12'(4*c), d, e);
      total++; if (d !== m_peak[c]) begin bad++; $display("FAIL rand_peak%0d: got %0d want %0d", c, d, m_peak[c]); end
      apb_read(12'h040 + 12'(4*c), d, e);
      total++; if (d !== m_snap[c]) begin bad++; $display("FAIL rand_snap%0d: got %0d want %0d", c, d, m_snap[c]); end
    end
    apb_read(12'h008, d, e);
    total++; if (d !== {28'b0, m_flags}) begin bad++; $display("FAIL rand_flags: got %h want %h", d, m_flags); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        e;
    apb_write(12'h010, 32'h0, -1, 0, e);
    apb_write(12'h00C, 32'hF, -1, 0, e);
    apb_write(12'h004, 32'h1, -1, 0, e);
    drive_sample(3, 5); tick();
    tick();
    apb_read(12'h000, d, e);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h080; PWDATA = 32'h0;
    tick();
    PENABLE = 1'b1;
    #2;
    total++; if (PSLVERR !== 1'b1) begin bad++; $display("FAIL pre_reset_err: got %b want 1", PSLVERR); end
    total++; if (PRDATA !== 32'h3000_041B) begin bad++; $display("FAIL pre_reset_prdata: got %h want 3000041b", PRDATA); end
    #1;
    PRESETn = 1'b0;
    model_reset();
    #1;
    total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL mid_reset_prdata: got %h want 0", PRDATA); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
    total++; if (PSLVERR !== 1'b0) begin bad++; $display("FAIL mid_reset_err: got %b want 0", PSLVERR); end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb_read(12'h004, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_ctrl: got %h want 0", d); end
    apb_read(12'h00C, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_irq_en: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_peak();
    test_flags();
    test_snap();
    test_unmapped();
    test_disable();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
